div_sequencer: RTL and testbench

- Multi-cycle controller and datapath for the RV32M divide and remainder operations: DIV, DIVU, REM and REMU.
- Sits beside the single-cycle ALU in the execute stage.
- The main decoder routes M-extension divide ops (funct7=0000001, funct3[2]=1) here instead of the ALU.
- While an op is in flight, the block holds the pipeline via busy_o.
- Uses an iterative radix-2 restoring algorithm: one quotient bit per cycle, plus fast paths for the architecturally defined corner cases.

---
 rtl/div_sequencer.sv | 176 +++++++++++++++++
 tb/tb_div_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle, with single-cycle fast paths for divide-by-zero and signed overflow.
module div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  logic [1:0]      state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [XLEN-1:0] rem_q,    rem_d;
  logic [XLEN-1:0] quo_q,    quo_d;
  logic [XLEN-1:0] dvs_q,    dvs_d;
  logic            neg_q,    neg_d;
  logic            is_rem_q, is_rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q,   done_d;
  logic            busy_q,   busy_d;

  logic            signed_op_s;
  logic            sign_a_s;
  logic            sign_b_s;
  logic [XLEN-1:0] mag_a_s;
  logic [XLEN-1:0] mag_b_s;
  logic            div_zero_s;
  logic            overflow_s;
  logic [XLEN-1:0] fast_res_s;
  logic            accept_s;

  logic [XLEN:0]   rem_wide_s;
  logic [XLEN+1:0] trial_s;
  logic            ge_s;
  logic [XLEN-1:0] rem_next_s;
  logic [XLEN-1:0] quo_next_s;
  logic [XLEN-1:0] sel_s;
  logic [XLEN-1:0] final_s;

  // Operand conditioning: magnitudes, sign flags and corner-case detection at accept time.
  always_comb begin
    signed_op_s = ~funct3_i[0];
    sign_a_s    = signed_op_s & src_a_i[XLEN-1];
    sign_b_s    = signed_op_s & src_b_i[XLEN-1];
    mag_a_s     = sign_a_s ? (ZERO - src_a_i) : src_a_i;
    mag_b_s     = sign_b_s ? (ZERO - src_b_i) : src_b_i;
    div_zero_s  = (src_b_i == ZERO);
    overflow_s  = signed_op_s & (src_a_i == MIN_NEG) & (src_b_i == ALL_ONES);
    accept_s    = start_i & ~kill_i & funct3_i[2];
    if (div_zero_s) begin
      fast_res_s = funct3_i[1] ? src_a_i : ALL_ONES;
    end else begin
      fast_res_s = funct3_i[1] ? ZERO : MIN_NEG;
    end
  end

  // One restoring step; the extra top bit keeps the shifted remainder and the trial sign exact.
  always_comb begin
    rem_wide_s = {rem_q, quo_q[XLEN-1]};
    trial_s    = {1'b0, rem_wide_s} - {2'b00, dvs_q};
    ge_s       = ~trial_s[XLEN+1];
    if (ge_s) begin
      rem_next_s = trial_s[XLEN-1:0];
    end else begin
      rem_next_s = rem_wide_s[XLEN-1:0];
    end
    quo_next_s = {quo_q[XLEN-2:0], ge_s};
    sel_s      = is_rem_q ? rem_next_s : quo_next_s;
    final_s    = neg_q ? (ZERO - sel_s) : sel_s;
  end

  // Next-state logic for the IDLE/CALC/DONE sequencer; kill_i overrides every transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    neg_d    = neg_q;
    is_rem_d = is_rem_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          is_rem_d = funct3_i[1];
          neg_d    = funct3_i[1] ? sign_a_s : (sign_a_s ^ sign_b_s);
          rem_d    = ZERO;
          quo_d    = mag_a_s;
          dvs_d    = mag_b_s;
          if (div_zero_s || overflow_s) begin
            result_d = fast_res_s;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            cnt_d    = CNT_W'(XLEN - 1);
            state_d  = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_next_s;
          quo_d = quo_next_s;
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == {CNT_W{1'b0}}) begin
            result_d = final_s;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      rem_q    <= ZERO;
      quo_q    <= ZERO;
      dvs_q    <= ZERO;
      neg_q    <= 1'b0;
      is_rem_q <= 1'b0;
      result_q <= ZERO;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      neg_q    <= neg_d;
      is_rem_q <= is_rem_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed RV32M corner cases, kill/reset/back-to-back
// scenarios and a randomized sweep compared against a plain-arithmetic reference model.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [2:0]  f3;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  div_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .funct3_i (f3),
    .src_a_i  (a),
    .src_b_i  (b),
    .kill_i   (kill),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (res)
  );

  always #5 clk = ~clk;

  // Reference result straight from the RISC-V M rules.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb);
    int          sa;
    int          sb;
    int unsigned ua;
    int unsigned ub;
    sa = xa; sb = xb; ua = xa; ub = xb;
    if (xb == 32'd0) return op[1] ? xa : 32'hFFFF_FFFF;
    if (!op[0] && xa == 32'h8000_0000 && xb == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    return op[1] ? 32'(ua % ub) : 32'(ua / ub);
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb);
    if (xb == 32'd0) return 1;
    if (!op[0] && xa == 32'h8000_0000 && xb == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op and observe it; called at #1 after a rising edge with the DUT idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb,
                        input bit keep, input bit pulse,
                        output int lat, output int busy_bad, output logic [31:0] r,
                        output logic post_busy, output logic post_done, output logic [31:0] post_res);
    lat = 0; busy_bad = 0; r = 32'd0;
    f3 = op; a = xa; b = xb; start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1) busy_bad++;
      if (pulse) begin
        if (n == 1) start = 1'b0;
        else if (n == 15) begin start = 1'b1; a = $urandom; b = $urandom; end
        else if (n == 16) start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = n;
        r = res;
        break;
      end
    end
    if (!keep) start = 1'b0;
    @(posedge clk); #1;
    post_busy = busy; post_done = done; post_res = res;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; f3 = 3'b000; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || res !== 32'd0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b result=%h want 0 0 00000000", busy, done, res);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] xa;
    logic [31:0] xb;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t dir_v [12] = '{
    '{3'b101, 32'd100,        32'd7,         32'd14,         33},
    '{3'b111, 32'd100,        32'd7,         32'd2,          33},
    '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD,  33},
    '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF,  33},
    '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,          33},
    '{3'b100, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF,  1},
    '{3'b111, 32'h1234_5678,  32'd0,         32'h1234_5678,  1},
    '{3'b110, 32'h1234_5678,  32'd0,         32'h1234_5678,  1},
    '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  1},
    '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,          1},
    '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,          33},
    '{3'b111, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  33}
  };

  task automatic test_directed;
    int lat, bb;
    logic [31:0] r, pr;
    logic pb, pd;
    for (int i = 0; i < 12; i++) begin
      run_op(dir_v[i].op, dir_v[i].xa, dir_v[i].xb, 1'b0, 1'b0, lat, bb, r, pb, pd, pr);
      checks++;
      if (lat != dir_v[i].lat) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d want %0d", i, lat, dir_v[i].lat);
      end
      checks++;
      if (r !== dir_v[i].exp) begin
        errors++;
        $display("FAIL dir%0d_result got %h want %h", i, r, dir_v[i].exp);
      end
      checks++;
      if (bb != 0) begin
        errors++;
        $display("FAIL dir%0d_busy low in %0d cycles want 0", i, bb);
      end
      checks++;
      if (pb !== 1'b0 || pd !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_after busy=%b done=%b want 0 0", i, pb, pd);
      end
      checks++;
      if (pr !== dir_v[i].exp) begin
        errors++;
        $display("FAIL dir%0d_hold got %h want %h", i, pr, dir_v[i].exp);
      end
    end
  endtask

  task automatic test_kill;
    int lat, bb, early;
    logic [31:0] r, pr;
    logic pb, pd;
    run_op(3'b101, 32'd100, 32'd7, 1'b0, 1'b0, lat, bb, r, pb, pd, pr);
    f3 = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
    early = 0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) early++;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || early != 0) begin
      errors++;
      $display("FAIL kill_calc busy=%b done=%b early_done=%0d want 0 0 0", busy, done, early);
    end
    checks++;
    if (res !== 32'd14) begin
      errors++;
      $display("FAIL kill_keep got %h want 0000000e", res);
    end
    run_op(3'b101, 32'd1000, 32'd3, 1'b0, 1'b0, lat, bb, r, pb, pd, pr);
    checks++;
    if (lat != 33 || r !== 32'd333) begin
      errors++;
      $display("FAIL kill_restart latency %0d result %h want 33 0000014d", lat, r);
    end
    f3 = 3'b100; a = 32'd50; b = 32'd5; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    checks++;
    if (busy !== 1'b0 || res !== 32'd333) begin
      errors++;
      $display("FAIL kill_idle busy=%b result=%h want 0 0000014d", busy, res);
    end
  endtask

  task automatic test_illegal;
    int seen;
    seen = 0;
    f3 = 3'b011; a = 32'd9; b = 32'd3; start = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) seen++;
    end
    start = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL illegal_funct3 active in %0d cycles want 0", seen);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    f3 = 3'b100; a = 32'hDEAD_BEEF; b = 32'd13; start = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || res !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b result=%h want 0 0 00000000", busy, done, res);
    end
    rst_n = 1'b1; start = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_discard activity in %0d cycles want 0", seen);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bb;
    logic [31:0] r, pr, xa, xb;
    logic pb, pd;
    xa = 32'hCAFE_1234; xb = 32'h0000_0123;
    run_op(3'b100, xa, xb, 1'b0, 1'b1, lat, bb, r, pb, pd, pr);
    checks++;
    if (lat != 33 || r !== model(3'b100, xa, xb)) begin
      errors++;
      $display("FAIL ignore_start latency %0d result %h want 33 %h", lat, r, model(3'b100, xa, xb));
    end
    checks++;
    if (pb !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_after busy=%b want 0", pb);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bb;
    logic [31:0] r, pr;
    logic pb, pd;
    run_op(3'b111, 32'd1000, 32'd7, 1'b1, 1'b0, lat, bb, r, pb, pd, pr);
    checks++;
    if (lat != 33 || r !== 32'd6) begin
      errors++;
      $display("FAIL b2b_first latency %0d result %h want 33 00000006", lat, r);
    end
    checks++;
    if (pb !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_start busy=%b want 0", pb);
    end
    run_op(3'b100, 32'hFFFF_FF9C, 32'd9, 1'b0, 1'b0, lat, bb, r, pb, pd, pr);
    checks++;
    if (lat != 33 || r !== 32'hFFFF_FFF5) begin
      errors++;
      $display("FAIL b2b_second latency %0d result %h want 33 fffffff5", lat, r);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 15));
      5: return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    int lat, bb;
    logic [31:0] r, pr, xa, xb, exp;
    logic [2:0] op;
    logic [1:0] sel;
    logic pb, pd;
    for (int i = 0; i < 600; i++) begin
      sel = 2'($urandom_range(0, 3));
      op = {1'b1, sel};
      xa = pick_operand();
      xb = pick_operand();
      exp = model(op, xa, xb);
      run_op(op, xa, xb, 1'b0, 1'b0, lat, bb, r, pb, pd, pr);
      checks++;
      if (r !== exp || lat != model_lat(op, xa, xb) || bb != 0) begin
        errors++;
        $display("FAIL rand%0d op=%b a=%h b=%h got %h lat %0d want %h lat %0d",
                 i, op, xa, xb, r, lat, exp, model_lat(op, xa, xb));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_kill();
    test_illegal();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
